// File: rtl/lfsr_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// lfsr_run_ctrl_if
//   Bundles the control, configuration and datapath-facing signals of the
//   LFSR run sequencer.
//
//   master : drives the run requests and configuration, and returns the
//            datapath state x. It observes the sequencer outputs.
//   slave  : the sequencer itself (lfsr_run_ctrl).
//
//   Signals
//     start, abort          run request / cancel
//     run_len[CNT_W-1:0]    number of RUN cycles
//     cont_mode[1:0]        injection mode (00 off, 01 static, 10 walk, 11 off)
//     cont_pat[2:0]         static injection pattern
//     expect_sig[5:0]       expected signature
//     x[5:0]                datapath state {x5..x0}
//     lfsr_rst              datapath clear
//     cont[2:0]             injection lines {cont3,cont2,cont1}
//     busy, done, pass      run status
//     sig[5:0]              running / final signature
// ---------------------------------------------------------------------------
interface lfsr_run_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] run_len;
  logic [1:0]       cont_mode;
  logic [2:0]       cont_pat;
  logic [5:0]       expect_sig;
  logic [5:0]       x;
  logic             lfsr_rst;
  logic [2:0]       cont;
  logic             busy;
  logic             done;
  logic             pass;
  logic [5:0]       sig;

  modport master (
    output start, abort, run_len, cont_mode, cont_pat, expect_sig, x,
    input  lfsr_rst, cont, busy, done, pass, sig
  );

  modport slave (
    input  start, abort, run_len, cont_mode, cont_pat, expect_sig, x,
    output lfsr_rst, cont, busy, done, pass, sig
  );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_run_ctrl
//   Sequencer for the dual-chain LFSR datapath. A run clears the datapath
//   for one cycle, then drives the injection lines for run_len cycles while
//   compressing x[5:0] into a 6-bit rotating-XOR signature, and finally
//   reports the signature comparison with a one-cycle done pulse.
//
//   Ports
//     clock   system clock, rising edge
//     reset   synchronous, active-high reset
//     bus     lfsr_run_ctrl_if slave modport (see interface header)
//
//   All outputs are registered: each output register is loaded with the
//   value belonging to the state being entered on that edge.
// ---------------------------------------------------------------------------
module lfsr_run_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  lfsr_run_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [1:0]       mode_q, mode_d;
  logic [2:0]       pat_q, pat_d;
  logic [5:0]       expect_q, expect_d;
  logic             lfsr_rst_q, lfsr_rst_d;
  logic [2:0]       cont_q, cont_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [5:0]       sig_q, sig_d;

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_len_d  = run_len_q;
    mode_d     = mode_q;
    pat_d      = pat_q;
    expect_d   = expect_q;
    sig_d      = sig_q;
    pass_d     = pass_q;
    lfsr_rst_d = 1'b0;
    cont_d     = 3'b000;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // start takes priority over abort here; abort has no meaning in IDLE
        if (bus.start) begin
          run_len_d = bus.run_len;
          mode_d    = bus.cont_mode;
          pat_d     = bus.cont_pat;
          expect_d  = bus.expect_sig;
          sig_d     = 6'd0;
          pass_d    = 1'b0;
          state_d   = CLR;
        end
      end

      CLR: begin
        cnt_d = '0;
        if (bus.abort) begin
          sig_d   = 6'd0;
          pass_d  = 1'b0;
          state_d = IDLE;
        end else if (run_len_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.abort) begin
          sig_d   = 6'd0;
          pass_d  = 1'b0;
          state_d = IDLE;
        end else begin
          sig_d = {sig_q[4:0], sig_q[5]} ^ bus.x;
          cnt_d = cnt_q + CNT_W'(1);
          // run_len_q is non-zero here (zero-length runs skip RUN), so the
          // subtraction cannot underflow and cnt never exceeds run_len.
          if (cnt_q == run_len_q - CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs follow the state being entered.
    lfsr_rst_d = (state_d == CLR);
    busy_d     = (state_d != IDLE);
    // DONE is only ever entered from CLR or RUN, so this is a single pulse.
    done_d     = (state_d == DONE);
    if (state_d == DONE) begin
      pass_d = (sig_d == expect_q);
    end

    if (state_d == RUN) begin
      unique case (mode_q)
        2'b01:   cont_d = pat_q;
        // Walking one: seed on the first RUN cycle, then rotate left.
        2'b10:   cont_d = (state_q == CLR) ? 3'b001 : {cont_q[1:0], cont_q[2]};
        default: cont_d = 3'b000;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      run_len_q  <= '0;
      mode_q     <= 2'b00;
      pat_q      <= 3'b000;
      expect_q   <= 6'd0;
      lfsr_rst_q <= 1'b0;
      cont_q     <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      sig_q      <= 6'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_len_q  <= run_len_d;
      mode_q     <= mode_d;
      pat_q      <= pat_d;
      expect_q   <= expect_d;
      lfsr_rst_q <= lfsr_rst_d;
      cont_q     <= cont_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      sig_q      <= sig_d;
    end
  end

  assign bus.lfsr_rst = lfsr_rst_q;
  assign bus.cont     = cont_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.sig      = sig_q;

endmodule
